// File: rtl/rhd_spi_sequencer.sv
// SPI master for the RHD headset ports: shifts one 16-bit command per frame and
// captures one 16-bit word from each of the 16 MISO lines into a 256-bit bundle.
module rhd_spi_sequencer #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [15:0]  cmd_data,
  output logic         CS_N,
  output logic         SCLK,
  output logic         MOSI,
  input  logic [15:0]  MISO,
  output logic         rsp_valid,
  output logic [255:0] rsp_data,
  output logic         busy
);

  localparam int unsigned NUM_LINES = 16;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned CNT_MAX   = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_HIGH_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]                  state, state_nx;
  logic [CNT_W-1:0]            cnt, cnt_nx;
  logic [3:0]                  bit_cnt, bit_nx;
  logic [WORD_W-1:0]           tx, tx_nx;
  logic [NUM_LINES*WORD_W-1:0] rx, rx_nx;
  logic [NUM_LINES-1:0]        mq;
  logic                        cs_n_nx, sclk_nx, mosi_nx, ready_nx, rsp_valid_nx, busy_nx;
  logic [NUM_LINES*WORD_W-1:0] rsp_data_nx;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      mq        <= '0;
      CS_N      <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_cnt   <= bit_nx;
      tx        <= tx_nx;
      rx        <= rx_nx;
      mq        <= MISO;
      CS_N      <= cs_n_nx;
      SCLK      <= sclk_nx;
      MOSI      <= mosi_nx;
      cmd_ready <= ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
      busy      <= busy_nx;
    end
  end

  // Next state and next output values; outputs are the registered copies of these
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + CNT_W'(1);
    bit_nx       = bit_cnt;
    tx_nx        = tx;
    rx_nx        = rx;
    cs_n_nx      = CS_N;
    sclk_nx      = SCLK;
    mosi_nx      = MOSI;
    ready_nx     = cmd_ready;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (cmd_valid) begin
          state_nx = S_SETUP;
          tx_nx    = cmd_data;
          cs_n_nx  = 1'b0;
          mosi_nx  = cmd_data[15];
          ready_nx = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt == DIV_LAST) begin
          cnt_nx   = '0;
          state_nx = S_SHIFT;
          sclk_nx  = 1'b1;
          bit_nx   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (SCLK) begin
            // End of a high phase: capture, then drop SCLK and advance MOSI
            for (int k = 0; k < NUM_LINES; k++) begin
              rx_nx[k*WORD_W +: WORD_W] = {rx[k*WORD_W +: WORD_W-1], mq[k]};
            end
            sclk_nx = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_nx = S_HOLD;
            end else begin
              mosi_nx = tx[14];
              tx_nx   = {tx[14:0], 1'b0};
            end
          end else begin
            sclk_nx = 1'b1;
            bit_nx  = bit_cnt + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == DIV_LAST) begin
          cnt_nx       = '0;
          state_nx     = S_GAP;
          cs_n_nx      = 1'b1;
          mosi_nx      = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = rx;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
          ready_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        cs_n_nx  = 1'b1;
        sclk_nx  = 1'b0;
        mosi_nx  = 1'b0;
        ready_nx = 1'b1;
      end
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_rhd_spi_sequencer.sv
// Directed bench for rhd_spi_sequencer: default timing on one instance,
// CLK_DIV=3 / CS_HIGH_CYCLES=1 on a second.
module tb_rhd_spi_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         cmd_valid_a, cmd_ready_a, cs_n_a, sclk_a, mosi_a, rsp_valid_a, busy_a;
  logic [15:0]  cmd_data_a, miso_a;
  logic [255:0] rsp_data_a;
  logic         cmd_valid_b, cmd_ready_b, cs_n_b, sclk_b, mosi_b, rsp_valid_b, busy_b;
  logic [15:0]  cmd_data_b, miso_b;
  logic [255:0] rsp_data_b;

  rhd_spi_sequencer #(.CLK_DIV(2), .CS_HIGH_CYCLES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data_a), .CS_N(cs_n_a), .SCLK(sclk_a), .MOSI(mosi_a), .MISO(miso_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a));

  rhd_spi_sequencer #(.CLK_DIV(3), .CS_HIGH_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data_b), .CS_N(cs_n_b), .SCLK(sclk_b), .MOSI(mosi_b), .MISO(miso_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-frame measurements
  logic [15:0] r_mosi;
  int r_cs_low, r_rises, r_hi_min, r_hi_max, r_lo_min, r_lo_max;
  int r_rsp_at, r_rsp_n, r_gap, r_period;
  bit r_to;

  int rv_cnt_a = 0;
  always @(negedge clk) if (rsp_valid_a === 1'b1) rv_cnt_a++;

  // Called at a negedge; runs one frame and returns at the negedge where cmd_ready is back
  task automatic frame(input bit sel, input logic [15:0] cmd, input logic [255:0] mw, input bit keep);
    int n, run;
    logic cs, sc, mo, rv, bz, rdy, prev;
    if (sel) begin cmd_data_b = cmd; cmd_valid_b = 1'b1; end
    else     begin cmd_data_a = cmd; cmd_valid_a = 1'b1; end
    r_mosi = '0; r_cs_low = 0; r_rises = 0; r_hi_min = 999; r_hi_max = 0;
    r_lo_min = 999; r_lo_max = 0; r_rsp_at = -1; r_rsp_n = 0; r_gap = 0;
    r_period = 0; r_to = 1'b0;
    n = 0;
    while (!(sel ? cmd_ready_b : cmd_ready_a)) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        r_to = 1'b1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        return;
      end
    end
    @(posedge clk);
    prev = 1'b0;
    run  = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) begin
        if (sel) cmd_valid_b = 1'b0; else cmd_valid_a = 1'b0;
      end
      cs  = sel ? cs_n_b      : cs_n_a;
      sc  = sel ? sclk_b      : sclk_a;
      mo  = sel ? mosi_b      : mosi_a;
      rv  = sel ? rsp_valid_b : rsp_valid_a;
      bz  = sel ? busy_b      : busy_a;
      rdy = sel ? cmd_ready_b : cmd_ready_a;
      if (!cs) r_cs_low++;
      if (cs && bz) r_gap++;
      if (rv) begin r_rsp_n++; r_rsp_at = c; end
      if (sc != prev) begin
        if (prev) begin
          if (run < r_hi_min) r_hi_min = run;
          if (run > r_hi_max) r_hi_max = run;
        end else if (r_rises > 0) begin
          if (run < r_lo_min) r_lo_min = run;
          if (run > r_lo_max) r_lo_max = run;
        end
        run = 1;
      end else begin
        run++;
      end
      if (sc && !prev) begin
        r_mosi = {r_mosi[14:0], mo};
        r_rises++;
      end
      // New MISO bit is presented during the low phase before its high phase
      if (!sc && r_rises < 16) begin
        for (int k = 0; k < 16; k++) begin
          if (sel) miso_b[k] = mw[16*k + 15 - r_rises];
          else     miso_a[k] = mw[16*k + 15 - r_rises];
        end
      end
      prev = sc;
      if (rdy) begin r_period = c; break; end
    end
    if (r_period == 0) r_to = 1'b1;
  endtask

  logic [255:0] pat1, pat2, pat3, pat4, pat_b;
  int rv_snap, rises;
  logic prev_sc;

  initial begin
    rst_n = 1'b0;
    cmd_valid_a = 1'b0; cmd_data_a = '0; miso_a = '0;
    cmd_valid_b = 1'b0; cmd_data_b = '0; miso_b = '0;
    for (int k = 0; k < 16; k++) begin
      pat1[16*k +: 16] = 16'((k << 12) | k);
      pat2[16*k +: 16] = 16'h1234 ^ 16'(k * 16'h0111);
      pat3[16*k +: 16] = 16'h0F0F;
      pat4[16*k +: 16] = 16'hC001 + 16'(k);
      pat_b[16*k +: 16] = 16'hAAAA;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 256'(cs_n_a), 256'(1));
    chk("rst_sclk", 256'(sclk_a), 256'(0));
    chk("rst_mosi", 256'(mosi_a), 256'(0));
    chk("rst_ready", 256'(cmd_ready_a), 256'(1));
    chk("rst_busy", 256'(busy_a), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid_a), 256'(0));
    chk("rst_rsp_data", rsp_data_a, 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single command with per-line mapping pattern
    frame(1'b0, 16'hA5C3, pat1, 1'b0);
    chk("t1_timeout", 256'(r_to), 256'(0));
    chk("t1_mosi", 256'(r_mosi), 256'h A5C3);
    chk("t1_cs_low", 256'(r_cs_low), 256'(66));
    chk("t1_pulses", 256'(r_rises), 256'(16));
    chk("t1_hi_min", 256'(r_hi_min), 256'(2));
    chk("t1_hi_max", 256'(r_hi_max), 256'(2));
    chk("t1_lo_min", 256'(r_lo_min), 256'(2));
    chk("t1_lo_max", 256'(r_lo_max), 256'(2));
    chk("t1_rsp_n", 256'(r_rsp_n), 256'(1));
    chk("t1_rsp_at", 256'(r_rsp_at), 256'(67));
    chk("t1_period", 256'(r_period), 256'(71));
    chk("t1_gap", 256'(r_gap), 256'(4));
    chk("t1_rsp_data", rsp_data_a, pat1);
    chk("t1_line5", 256'(rsp_data_a[95:80]), 256'h5005);

    // Back-to-back, cmd_valid held high through the first frame
    frame(1'b0, 16'h0001, pat2, 1'b1);
    chk("b2b1_timeout", 256'(r_to), 256'(0));
    chk("b2b1_mosi", 256'(r_mosi), 256'h0001);
    chk("b2b1_cs_low", 256'(r_cs_low), 256'(66));
    chk("b2b1_rsp_n", 256'(r_rsp_n), 256'(1));
    chk("b2b1_period", 256'(r_period), 256'(71));
    chk("b2b1_gap", 256'(r_gap), 256'(4));
    chk("b2b1_rsp_data", rsp_data_a, pat2);
    frame(1'b0, 16'h8000, pat3, 1'b0);
    chk("b2b2_timeout", 256'(r_to), 256'(0));
    chk("b2b2_mosi", 256'(r_mosi), 256'h8000);
    chk("b2b2_rsp_n", 256'(r_rsp_n), 256'(1));
    chk("b2b2_rsp_at", 256'(r_rsp_at), 256'(67));
    chk("b2b2_rsp_data", rsp_data_a, pat3);
    repeat (5) @(negedge clk);
    chk("hold_rsp_data", rsp_data_a, pat3);

    // Reset during bit 7 of SHIFT
    cmd_data_a = 16'h3C3C;
    cmd_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    rises = 0;
    prev_sc = 1'b0;
    for (int c = 0; c < 200 && rises < 8; c++) begin
      @(negedge clk);
      if (sclk_a && !prev_sc) rises++;
      prev_sc = sclk_a;
    end
    chk("rst_mid_reached", 256'(rises), 256'(8));
    rv_snap = rv_cnt_a;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", 256'(cs_n_a), 256'(1));
    chk("rst_mid_sclk", 256'(sclk_a), 256'(0));
    chk("rst_mid_busy", 256'(busy_a), 256'(0));
    chk("rst_mid_ready", 256'(cmd_ready_a), 256'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("rst_mid_no_rsp", 256'(rv_cnt_a - rv_snap), 256'(0));
    chk("rst_mid_rsp_data", rsp_data_a, 256'(0));
    frame(1'b0, 16'hFFFF, pat4, 1'b0);
    chk("post_rst_timeout", 256'(r_to), 256'(0));
    chk("post_rst_mosi", 256'(r_mosi), 256'hFFFF);
    chk("post_rst_cs_low", 256'(r_cs_low), 256'(66));
    chk("post_rst_rsp_at", 256'(r_rsp_at), 256'(67));
    chk("post_rst_rsp_data", rsp_data_a, pat4);

    // CLK_DIV=3, CS_HIGH_CYCLES=1
    @(negedge clk);
    frame(1'b1, 16'h5A96, pat_b, 1'b0);
    chk("d3_timeout", 256'(r_to), 256'(0));
    chk("d3_mosi", 256'(r_mosi), 256'h5A96);
    chk("d3_pulses", 256'(r_rises), 256'(16));
    chk("d3_hi_min", 256'(r_hi_min), 256'(3));
    chk("d3_hi_max", 256'(r_hi_max), 256'(3));
    chk("d3_lo_min", 256'(r_lo_min), 256'(3));
    chk("d3_lo_max", 256'(r_lo_max), 256'(3));
    chk("d3_cs_low", 256'(r_cs_low), 256'(99));
    chk("d3_rsp_at", 256'(r_rsp_at), 256'(100));
    chk("d3_period", 256'(r_period), 256'(101));
    chk("d3_gap", 256'(r_gap), 256'(1));
    chk("d3_rsp_data", rsp_data_b, pat_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
